mem_tracer_ctrl: RTL

- Programmable sequencer that drives the 4-bit trace control vector and the flush address of the sigma_tile memory tracer.
- Holds CPU-visible config/status registers on a simple word-addressed config port.
- Observes the CPU data bus so it can start tracing on an address trigger, stop after N transactions, and run a full-capacity flush sequence.
- Sits between the tile's peripheral bus and the tracer's trace_ctrl_i / trace_flush_end.

---
 rtl/mem_tracer_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/mem_tracer_ctrl.sv
// rtl/mem_tracer_ctrl.sv - trace control sequencer for the sigma_tile memory tracer
//
// Drives the tracer's enable/flush control vector and flush entry index, and
// exposes config/status registers on a word-addressed config port.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_req/we/addr/wdata  config access; cfg_ack is combinational (no wait states)
//   cfg_rdata           registered read data, valid the cycle after ack
//   mon_req/ack/we/addr monitored CPU data bus (acc = req & ack)
//   trace_ctrl_o        tracer control vector (enable, flush; bits 3:2 zero)
//   flush_addr_o        current flush entry index
//   trace_flush_end_o   one-cycle pulse after the last flush entry
//   irq_o               level interrupt, mirrors STATUS.DONE
module mem_tracer_ctrl #(
   parameter int  CAPACITY        = 256,
   parameter int  TRACE_EN_BIT    = 0,
   parameter int  TRACE_FLUSH_BIT = 1,
   localparam int FA_W            = $clog2(CAPACITY)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_req,
   input  logic            cfg_we,
   input  logic [4:0]      cfg_addr,
   input  logic [31:0]     cfg_wdata,
   output logic            cfg_ack,
   output logic [31:0]     cfg_rdata,
   input  logic            mon_req,
   input  logic            mon_ack,
   input  logic            mon_we,
   input  logic [31:0]     mon_addr,
   output logic [3:0]      trace_ctrl_o,
   output logic [FA_W-1:0] flush_addr_o,
   output logic            trace_flush_end_o,
   output logic            irq_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_ARMED = 3'd2,
      ST_TRACE = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   state_t            state, state_nxt;
   logic              arm, trig_en, done;
   logic [31:0]       trig_addr, stop_cnt, tran_cnt;
   logic [FA_W-1:0]   flush_cnt;
   logic              flush_end;

   logic              acc, trig_hit;
   logic              cfg_wr, cfg_rd, ctrl_wr, flush_wr, ctrl_upd;
   logic              arm_set, arm_clr, stop_hit, flush_last, trace_en;
   logic [2:0]        reg_sel;
   logic [31:0]       tran_inc, rd_val;
   logic              unused_inputs;

   assign unused_inputs = ^{mon_we, cfg_addr[1:0]};

   assign acc      = mon_req & mon_ack;
   assign trig_hit = acc & (mon_addr == trig_addr);

   assign cfg_ack  = cfg_req;
   assign cfg_wr   = cfg_req & cfg_we;
   assign cfg_rd   = cfg_req & ~cfg_we;
   assign reg_sel  = cfg_addr[4:2];
   assign ctrl_wr  = cfg_wr & (reg_sel == 3'd0);
   // A FLUSH write overrides every other CTRL field; while flushing, only a
   // new FLUSH write is honoured on CTRL.
   assign flush_wr = ctrl_wr & cfg_wdata[1];
   assign ctrl_upd = ctrl_wr & ~flush_wr & (state != ST_FLUSH);
   assign arm_set  = ctrl_upd & cfg_wdata[0];
   assign arm_clr  = ctrl_upd & ~cfg_wdata[0];

   assign tran_inc   = (tran_cnt == 32'hFFFF_FFFF) ? tran_cnt : tran_cnt + 32'd1;
   assign stop_hit   = (state == ST_TRACE) & acc & (stop_cnt != 32'd0) & (tran_inc == stop_cnt);
   assign flush_last = (state == ST_FLUSH) & (flush_cnt == FA_W'(CAPACITY - 1));

   // Enable goes high combinationally on the trigger cycle so the triggering
   // transaction itself is captured; an ARM clear or FLUSH in that cycle wins.
   assign trace_en = (state == ST_TRACE) | (state == ST_DRAIN) |
                     ((state == ST_ARMED) & trig_hit & ~arm_clr & ~flush_wr);

   always_comb begin
      trace_ctrl_o                  = 4'd0;
      trace_ctrl_o[TRACE_EN_BIT]    = trace_en;
      trace_ctrl_o[TRACE_FLUSH_BIT] = (state == ST_FLUSH);
   end

   assign flush_addr_o      = flush_cnt;
   assign trace_flush_end_o = flush_end;
   assign irq_o             = done;

   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (flush_wr) begin
         state_nxt = ST_FLUSH;
      end else begin
         case (state)
            ST_IDLE:  if (arm_set) state_nxt = cfg_wdata[2] ? ST_ARMED : ST_TRACE;
            ST_ARMED: if (arm_clr) state_nxt = ST_IDLE;
                      else if (trig_hit) state_nxt = ST_TRACE;
            ST_TRACE: if (stop_hit | arm_clr) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_IDLE;
            ST_FLUSH: if (flush_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      rd_val = 32'd0;
      case (reg_sel)
         3'd0: rd_val = {29'd0, trig_en, 1'b0, arm};
         3'd1: rd_val = {28'd0, done, state};
         3'd2: rd_val = trig_addr;
         3'd3: rd_val = stop_cnt;
         3'd4: rd_val = tran_cnt;
         default: rd_val = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         arm       <= 1'b0;
         trig_en   <= 1'b0;
         done      <= 1'b0;
         trig_addr <= 32'd0;
         stop_cnt  <= 32'd0;
         tran_cnt  <= 32'd0;
         flush_cnt <= '0;
         flush_end <= 1'b0;
         cfg_rdata <= 32'd0;
      end else begin
         flush_end <= 1'b0;
         if (cfg_rd) cfg_rdata <= rd_val;
         if (cfg_wr && reg_sel == 3'd2) trig_addr <= cfg_wdata;
         if (cfg_wr && reg_sel == 3'd3) stop_cnt  <= cfg_wdata;
         // Clears come first so a DONE set in the same cycle takes precedence.
         if (cfg_wr && reg_sel == 3'd1 && cfg_wdata[3]) done <= 1'b0;
         if (ctrl_upd) begin
            arm     <= cfg_wdata[0];
            trig_en <= cfg_wdata[2];
         end
         if (arm_set) done <= 1'b0;

         if (flush_wr) begin
            tran_cnt  <= 32'd0;
            flush_cnt <= '0;
         end else begin
            case (state)
               ST_IDLE:  if (arm_set) tran_cnt <= 32'd0;
               ST_ARMED: if (trig_hit && !arm_clr) tran_cnt <= 32'd1;
               ST_TRACE: begin
                  if (acc) tran_cnt <= tran_inc;
                  if (stop_hit) done <= 1'b1;
               end
               ST_DRAIN: arm <= 1'b0;
               ST_FLUSH: begin
                  if (flush_last) begin
                     flush_cnt <= '0;
                     flush_end <= 1'b1;
                     arm       <= 1'b0;
                  end else begin
                     flush_cnt <= flush_cnt + FA_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule
